myproject_mul_rr_sched: RTL and testbench

Round-robin scheduler that shares one unsigned 31x16 multiplier, with the product truncated to 46 bits, among NUM_REQ requesters. Each requester has its own valid/ready request channel and response channel. The block issues at most one multiply per cycle, registers the result, and routes it back to the requester that issued it. It sits between the dense-layer MAC lanes of myproject and a single shared multiplier resource, trading throughput for DSP count.

---
 rtl/myproject_mul_rr_sched.sv | 113 +++++++++++
 tb/tb_myproject_mul_rr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_rr_sched.sv
// Round-robin scheduler sharing one unsigned A x B multiplier among NUM_REQ requesters.
// One issue per cycle into S1; the product lands in the issuing requester's result buffer.
`timescale 1ns/1ps
module myproject_mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 31,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 46
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*P_WIDTH-1:0]   rsp_p,
  output logic                         busy,
  output logic [31:0]                  issue_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic               s1_valid;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    last_grant;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  logic [P_WIDTH-1:0] prod;

  // A requester is eligible only when nothing of its own is in S1 and its buffer
  // is empty or being drained this cycle: at most one outstanding op each.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && !(s1_valid && s1_id == ID_W'(i)) &&
                (!rsp_valid[i] || rsp_ready[i]);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && elig[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        sel_a      = req_a[idx*A_WIDTH +: A_WIDTH];
        sel_b      = req_b[idx*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Reset is asynchronous, so the grant is masked to keep req_ready low while held.
  assign req_ready = ap_rst_n ? grant : '0;

  assign prod = P_WIDTH'({{B_WIDTH{1'b0}}, s1_a} * {{A_WIDTH{1'b0}}, s1_b});

  assign busy = s1_valid | (|rsp_valid);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_id       <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      issue_count <= '0;
      rsp_valid   <= '0;
      // NOTE: the result buffers are reset too, because rsp_p is visible at the
      // ports and must read zero after reset rather than stale products.
      rsp_p       <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_a        <= sel_a;
        s1_b        <= sel_b;
        s1_id       <= grant_id;
        last_grant  <= grant_id;
        issue_count <= issue_count + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (s1_valid && s1_id == ID_W'(i)) begin
          rsp_valid[i]                 <= 1'b1;
          rsp_p[i*P_WIDTH +: P_WIDTH]  <= prod;
        end
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_rr_sched.sv
// Directed bench for myproject_mul_rr_sched: vector table of single ops, then
// reset mid-op, full contention, backpressure and two-way fairness sequences.
`timescale 1ns/1ps
module tb_myproject_mul_rr_sched;

  localparam int N  = 4;
  localparam int AW = 31;
  localparam int BW = 16;
  localparam int PW = 46;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*PW-1:0]   rsp_p;
  logic              busy;
  logic [31:0]       issue_count;

  myproject_mul_rr_sched #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int            id;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] p;
  } vec_t;

  vec_t          vecs[6];
  int            errors = 0;
  int            checks = 0;
  int            exp_issue;
  logic [AW-1:0] op_a[N];
  logic [BW-1:0] op_b[N];
  logic [N-1:0]  oh;
  logic [N-1:0]  bp_exp[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
    op_a[i] = a;
    op_b[i] = b;
  endtask

  function automatic logic [PW-1:0] slot_p(input int i);
    return rsp_p[i*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] mulp(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [63:0] f;
    f = 64'(a) * 64'(b);
    return f[PW-1:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 31'd1000,        16'd3000,   46'd3000000};
    vecs[1] = '{0, 31'h7FFFFFFF,    16'hFFFF,   46'h3FFF7FFF0001};
    vecs[2] = '{1, 31'd0,           16'hFFFF,   46'd0};
    vecs[3] = '{3, 31'd12345,       16'd678,    46'd8369910};
    vecs[4] = '{2, 31'h40000000,    16'h8000,   46'h200000000000};
    vecs[5] = '{0, 31'h7FFFFFFF,    16'd1,      46'h7FFFFFFF};

    bp_exp[0] = 4'b0001;
    bp_exp[1] = 4'b0010;
    bp_exp[2] = 4'b1000;
    for (int c = 3; c <= 11; c++) bp_exp[c] = (c % 2 == 1) ? 4'b0001 : 4'b1000;
    bp_exp[12] = 4'b0010;

    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    ap_rst_n  = 1'b0;

    // Reset state, with requests pending to show req_ready is held low.
    repeat (2) @(negedge ap_clk);
    req_valid = '1;
    #1;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_issue_count", 64'(issue_count), 64'(0));
    check("reset_rsp_p_lo", 64'(rsp_p[63:0]), 64'(0));
    req_valid = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single ops from the table: grant at T, result at T+2.
    exp_issue = 0;
    for (int v = 0; v < 6; v++) begin
      oh = 4'(1 << vecs[v].id);
      @(negedge ap_clk);
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = oh;
      #1;
      check($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'(oh));
      exp_issue++;
      @(negedge ap_clk);
      req_valid = '0;
      #1;
      check($sformatf("vec%0d_busy_t1", v), 64'(busy), 64'(1));
      check($sformatf("vec%0d_rsp_valid_t1", v), 64'(rsp_valid), 64'(0));
      @(negedge ap_clk);
      #1;
      check($sformatf("vec%0d_rsp_valid_t2", v), 64'(rsp_valid), 64'(oh));
      check($sformatf("vec%0d_rsp_p", v), 64'(slot_p(vecs[v].id)), 64'(vecs[v].p));
      check($sformatf("vec%0d_issue_count", v), 64'(issue_count), 64'(exp_issue));
    end

    // Reset one cycle after an accept: everything clears at once, nothing stale follows.
    @(negedge ap_clk);
    set_op(2, 31'd5, 16'd7);
    req_valid = 4'b0100;
    #1;
    check("midrst_accept", 64'(req_ready), 64'(4'b0100));
    @(negedge ap_clk);
    req_valid = '0;
    ap_rst_n  = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_issue_count", 64'(issue_count), 64'(0));
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      #1;
      check($sformatf("midrst_no_stale%0d", c), 64'(rsp_valid), 64'(0));
    end

    // Full contention from reset: grants 0,1,2,3,0,1,2,3 and each result follows two cycles later.
    for (int i = 0; i < N; i++) set_op(i, 31'(100003 * (i + 1)), 16'(40000 + 1111 * i));
    exp_issue = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      if (c == 0) req_valid = '1;
      #1;
      check($sformatf("cont_grant%0d", c), 64'(req_ready), 64'(1 << (c % N)));
      exp_issue++;
      if (c >= 2) begin
        check($sformatf("cont_rsp_valid%0d", c), 64'(rsp_valid), 64'(1 << ((c - 2) % N)));
        check($sformatf("cont_rsp_p%0d", c), 64'(slot_p((c - 2) % N)),
              64'(mulp(op_a[(c - 2) % N], op_b[(c - 2) % N])));
        check($sformatf("cont_busy%0d", c), 64'(busy), 64'(1));
      end
    end
    @(negedge ap_clk);
    req_valid = '0;
    repeat (3) @(negedge ap_clk);

    // Backpressure on requester 1 while 0 and 3 keep issuing.
    set_op(0, 31'd77, 16'd11);
    set_op(1, 31'h12345678, 16'hBEEF);
    set_op(3, 31'd999, 16'd999);
    for (int c = 0; c <= 12; c++) begin
      @(negedge ap_clk);
      if (c == 0) begin
        req_valid = 4'b1011;
        rsp_ready = 4'b1101;
      end
      if (c == 12) begin
        rsp_ready = 4'b1111;
        set_op(1, 31'd4242, 16'd3);
      end
      #1;
      check($sformatf("bp_grant%0d", c), 64'(req_ready), 64'(bp_exp[c]));
      exp_issue++;
      if (c >= 3 && c <= 11) begin
        check($sformatf("bp_hold_valid%0d", c), 64'(rsp_valid[1]), 64'(1));
        check($sformatf("bp_hold_p%0d", c), 64'(slot_p(1)), 64'(mulp(31'h12345678, 16'hBEEF)));
      end
    end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("bp_drained", 64'(rsp_valid[1]), 64'(0));
    @(negedge ap_clk);
    #1;
    check("bp_new_valid", 64'(rsp_valid[1]), 64'(1));
    check("bp_new_p", 64'(slot_p(1)), 64'(46'd12726));
    repeat (3) @(negedge ap_clk);

    // Two continuously valid requesters alternate.
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      if (c == 0) req_valid = 4'b0011;
      #1;
      check($sformatf("fair_grant%0d", c), 64'(req_ready), 64'((c % 2 == 0) ? 4'b0001 : 4'b0010));
      exp_issue++;
    end
    @(negedge ap_clk);
    req_valid = '0;
    repeat (4) @(negedge ap_clk);
    #1;
    check("final_busy", 64'(busy), 64'(0));
    check("final_rsp_valid", 64'(rsp_valid), 64'(0));
    check("final_issue_count", 64'(issue_count), 64'(exp_issue));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
